// File: rtl/bsg_clk_gen_pearl_tag_sequencer.sv
// Round-robin bsg_tag packet sequencer: serialises whole requester packets onto tag_data_o/tag_en_o.
// Optional BSG_CLK_GEN_PEARL_TAG_SEQ_STATS_EN adds a completed-packet counter output pkt_count_o.
module bsg_clk_gen_pearl_tag_sequencer #(
  parameter int num_req_p           = 2,
  parameter int tag_els_p           = 16,
  parameter int tag_lg_width_p      = 4,
  parameter int max_payload_width_p = 8,
  parameter int gap_cycles_p        = 4,
  parameter int init_zeros_p        = 16,
  localparam int nid_w = (tag_els_p > 1) ? $clog2(tag_els_p) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic [num_req_p-1:0]                     v_i,
  input  logic [num_req_p*nid_w-1:0]               node_id_i,
  input  logic [num_req_p-1:0]                     data_not_reset_i,
  input  logic [num_req_p*tag_lg_width_p-1:0]      len_i,
  input  logic [num_req_p*max_payload_width_p-1:0] payload_i,
  output logic [num_req_p-1:0]                     ready_o,
  output logic                                     tag_data_o,
  output logic                                     tag_en_o,
  output logic                                     busy_o
`ifdef BSG_CLK_GEN_PEARL_TAG_SEQ_STATS_EN
  ,output logic [15:0]                             pkt_count_o
`endif
);

  localparam int REQ_W   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int SR_W    = nid_w + 1 + tag_lg_width_p + max_payload_width_p;
  localparam int PKT_MAX = SR_W + 1;
  localparam int CNT_MAX = (PKT_MAX > init_zeros_p)
                           ? ((PKT_MAX > gap_cycles_p) ? PKT_MAX : gap_cycles_p)
                           : ((init_zeros_p > gap_cycles_p) ? init_zeros_p : gap_cycles_p);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [tag_lg_width_p-1:0] MAX_LEN   = tag_lg_width_p'(max_payload_width_p);
  localparam logic [CNT_W-1:0]          HDR_BITS  = CNT_W'(1 + nid_w + tag_lg_width_p);
  localparam logic [CNT_W-1:0]          INIT_LAST = CNT_W'(init_zeros_p);
  localparam logic [CNT_W-1:0]          GAP_LAST  = CNT_W'(gap_cycles_p);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SHIFT, S_GAP} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SR_W-1:0]           sr_q, sr_d;
  logic [REQ_W-1:0]          ptr_q, ptr_d;
  logic                      data_q, data_d;
  logic                      en_q;
  logic                      busy_q;

  logic                      hi_v, lo_v, grant_v;
  logic [REQ_W-1:0]          hi_idx, lo_idx, grant_idx;
  logic [nid_w-1:0]          sel_nid;
  logic                      sel_dnr;
  logic [tag_lg_width_p-1:0] sel_len_raw, sel_len;
  logic [max_payload_width_p-1:0] sel_pay;

  // Round-robin without modulo: prefer the lowest valid index >= ptr, else the lowest valid index.
  always_comb begin
    hi_v   = 1'b0;
    lo_v   = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned r = 0; r < num_req_p; r++) begin
      if (v_i[r] && !hi_v && (r >= 32'(ptr_q))) begin
        hi_v   = 1'b1;
        hi_idx = REQ_W'(r);
      end
      if (v_i[r] && !lo_v) begin
        lo_v   = 1'b1;
        lo_idx = REQ_W'(r);
      end
    end
    grant_v   = (state_q == S_IDLE) && (hi_v || lo_v);
    grant_idx = hi_v ? hi_idx : lo_idx;
    ready_o   = '0;
    if (grant_v) ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_nid     = '0;
    sel_dnr     = 1'b0;
    sel_len_raw = '0;
    sel_pay     = '0;
    for (int unsigned r = 0; r < num_req_p; r++) begin
      if (grant_idx == REQ_W'(r)) begin
        sel_nid     = node_id_i[r*nid_w +: nid_w];
        sel_dnr     = data_not_reset_i[r];
        sel_len_raw = len_i[r*tag_lg_width_p +: tag_lg_width_p];
        sel_pay     = payload_i[r*max_payload_width_p +: max_payload_width_p];
      end
    end
    sel_len = (sel_len_raw > MAX_LEN) ? MAX_LEN : sel_len_raw;
  end

  // data_d is the bit presented during the state being entered, so outputs stay registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ptr_d   = ptr_q;
    data_d  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (grant_v) begin
          state_d = S_SHIFT;
          data_d  = 1'b1;
          sr_d    = {sel_pay, sel_len, sel_dnr, sel_nid};
          cnt_d   = HDR_BITS + CNT_W'(sel_len);
          ptr_d   = (grant_idx == REQ_W'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(1);
        end else begin
          data_d = sr_q[0];
          sr_d   = sr_q >> 1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      sr_q    <= '0;
      ptr_q   <= '0;
      data_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      en_q    <= 1'b1;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign tag_data_o = data_q;
  assign tag_en_o   = en_q;
  assign busy_o     = busy_q;

`ifdef BSG_CLK_GEN_PEARL_TAG_SEQ_STATS_EN
  logic [15:0] pkt_count_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_count_q <= '0;
    end else if ((state_q == S_GAP) && (cnt_q == GAP_LAST)) begin
      pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign pkt_count_o = pkt_count_q;
`endif

endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_sequencer.sv
// Scoreboard bench for bsg_clk_gen_pearl_tag_sequencer: a reference model predicts grants and
// pushes whole expected bit streams; a monitor pops one bit per cycle and compares the serial output.
module tb_bsg_clk_gen_pearl_tag_sequencer;

  localparam int N    = 2;
  localparam int NID  = 4;
  localparam int LG   = 4;
  localparam int MAXP = 8;
  localparam int GAP  = 4;
  localparam int INIT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      v = '0;
  logic [N*NID-1:0]  node = '0;
  logic [N-1:0]      dnr = '0;
  logic [N*LG-1:0]   len = '0;
  logic [N*MAXP-1:0] pay = '0;
  logic [N-1:0]      ready;
  logic              tag_data, tag_en, busy;
`ifdef BSG_CLK_GEN_PEARL_TAG_SEQ_STATS_EN
  logic [15:0]       pkt_count;
`endif

  bsg_clk_gen_pearl_tag_sequencer #(
    .num_req_p(N), .tag_els_p(16), .tag_lg_width_p(LG),
    .max_payload_width_p(MAXP), .gap_cycles_p(GAP), .init_zeros_p(INIT)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .node_id_i(node),
    .data_not_reset_i(dnr), .len_i(len), .payload_i(pay), .ready_o(ready),
    .tag_data_o(tag_data), .tag_en_o(tag_en), .busy_o(busy)
`ifdef BSG_CLK_GEN_PEARL_TAG_SEQ_STATS_EN
    , .pkt_count_o(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit exp_q[$];
  int m_remain = 0;
  bit tracking = 1'b0;
  int m_ptr = 0;
  int n_grants = 0;
  int m_pkts = 0;
  bit mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Expected serial stream for requester g: start, node, dnr, clamped len, payload, then gap zeros.
  task automatic push_packet(input int g);
    int nd, ln;
    logic [MAXP-1:0] p;
    nd = int'(node[g*NID +: NID]);
    ln = int'(len[g*LG +: LG]);
    if (ln > MAXP) ln = MAXP;
    p = pay[g*MAXP +: MAXP];
    exp_q.push_back(1'b1);
    for (int i = 0; i < NID; i++) exp_q.push_back(((nd >> i) & 1) == 1);
    exp_q.push_back(dnr[g]);
    for (int i = 0; i < LG; i++) exp_q.push_back(((ln >> i) & 1) == 1);
    for (int i = 0; i < ln; i++) exp_q.push_back(p[i]);
    for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
    m_remain = 2 + NID + LG + ln + GAP;
  endtask

  task automatic model_step();
    int g;
    logic [N-1:0] exp_rdy;
    if (m_remain > 0) begin
      check("ready_when_busy", 32'(ready), 32'd0);
      m_remain--;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("ready_grant", 32'(ready), 32'(exp_rdy));
      if (g >= 0) begin
        push_packet(g);
        m_ptr = (g + 1) % N;
        n_grants++;
        m_pkts++;
      end
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (tracking) model_step();
  end

  always @(negedge clk) begin
    if (tracking) begin
      if (exp_q.size() > 0) begin
        mon_b = exp_q.pop_front();
        check("tag_data", 32'(tag_data), 32'(mon_b));
        check("busy_active", 32'(busy), 32'd1);
      end else begin
        check("idle_data", 32'(tag_data), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
      end
      check("tag_en", 32'(tag_en), 32'd1);
    end
  end

  task automatic release_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i < INIT; i++) exp_q.push_back(1'b0);
    m_remain = INIT;
    tracking = 1'b1;
`ifdef BSG_CLK_GEN_PEARL_TAG_SEQ_STATS_EN
    check("pkt_count_after_reset", 32'(pkt_count), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(tag_data), 32'd0);
    check({tag, "_en"}, 32'(tag_en), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic rand_fields();
    node = (N*NID)'($urandom);
    dnr  = N'($urandom);
    len  = (N*LG)'($urandom);
    pay  = (N*MAXP)'($urandom);
  endtask

  task automatic send(input int r, input int nd, input bit d, input int ln, input int p);
    int start;
    int c;
    start = n_grants;
    node[r*NID +: NID] = NID'(nd);
    dnr[r] = d;
    len[r*LG +: LG] = LG'(ln);
    pay[r*MAXP +: MAXP] = MAXP'(p);
    v[r] = 1'b1;
    c = 0;
    while (n_grants == start && c < 200) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (n_grants == start) timeout("send_handshake");
    v[r] = 1'b0;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int c;
    c = 0;
    while (n_grants < target && c < budget) begin
      rand_fields();
      @(posedge clk);
      #2;
      c++;
    end
    if (n_grants < target) timeout("grant_count");
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((m_remain > 0 || exp_q.size() > 0) && c < 200) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (m_remain > 0) timeout("drain_idle");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    release_reset();

    // Directed packets from the test plan, plus an exact-max length.
    send(0, 5, 1'b1, 3, 'b101);
    send(1, 9, 1'b1, 15, 'hA5);
    send(0, 15, 1'b0, 0, 'h00);
    send(1, 3, 1'b0, 8, 'h3C);
    wait_idle();

    // Both requesters held: grants must alternate with no idle beyond the gap.
    v = '1;
    wait_grants(n_grants + 6, 600);
    v = '0;
    wait_idle();

    for (int c = 0; c < 400; c++) begin
      v = N'($urandom);
      rand_fields();
      @(posedge clk);
      #2;
    end
    v = '0;
    wait_idle();

    // Reset pulse mid-packet: outputs drop at once, INIT reruns, priority back to requester 0.
    v = '0;
    v[1] = 1'b1;
    node = '1; dnr = '1; len = '1; pay = '1;
    wait_grants(n_grants + 1, 100);
    v = '0;
    repeat (5) @(posedge clk);
    #2;
    tracking = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midpkt_reset");
    exp_q.delete();
    m_remain = 0;
    m_ptr = 0;
    m_pkts = 0;
    v = '1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("held_reset");
    release_reset();
    wait_grants(n_grants + 4, 400);
    v = '0;
    wait_idle();
    repeat (3) @(posedge clk);
    #2;
`ifdef BSG_CLK_GEN_PEARL_TAG_SEQ_STATS_EN
    check("pkt_count_final", 32'(pkt_count), 32'(m_pkts));
`endif
    check("final_busy", 32'(busy), 32'd0);
    tracking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
